// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: stores to TX_ADDR queue bytes in a FIFO, sent 8N1 LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] TX_ADDR     = 32'h000000FF,
  parameter logic [31:0] STATUS_ADDR = 32'h000000FE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] WD,
  input  logic        EN,
  output logic [31:0] RD,
  output logic        txd,
  output logic        busy
);

  localparam int unsigned DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(DIV);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_mmio: clocks per bit must be at least 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_mmio: FIFO_DEPTH must be a power of 2 in 2..64");
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic PARITY_FLAG = 1'b1;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic PARITY_FLAG = 1'b0;
`endif

  state_t        state_reg, state_next;
  logic [CW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          txd_reg, txd_next;
  logic          busy_reg;
  logic          overflow_reg;
`ifdef UART_TX_PARITY_EN
  logic          parity_reg, parity_next;
`endif

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;

  logic push_req, clr_req, push_ok, pop, full, empty, baud_done, tx_active;
  logic unused_wd;

  assign unused_wd = ^WD[31:8];
  assign push_req  = EN && (Address == TX_ADDR);
  assign clr_req   = EN && (Address == STATUS_ADDR);
  assign full      = (count_reg == (AW + 1)'(FIFO_DEPTH));
  assign empty     = (count_reg == '0);
  // A pop on the same edge frees a slot, so a push into a full FIFO is still taken.
  assign push_ok   = push_req && (!full || pop);
  assign baud_done = (baud_reg == CW'(DIV - 1));
  assign tx_active = (state_reg != IDLE);

  assign RD   = (Address == STATUS_ADDR) ?
                {27'b0, PARITY_FLAG, overflow_reg, tx_active, empty, full} : 32'b0;
  assign txd  = txd_reg;
  assign busy = busy_reg;

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (!push_ok && pop) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    txd_next    = txd_reg;
    pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        txd_next = 1'b1;
        if (!empty) begin
          pop         = 1'b1;
          shift_next  = fifo_mem[rd_ptr_reg];
`ifdef UART_TX_PARITY_EN
          parity_next = ^fifo_mem[rd_ptr_reg];
`endif
          state_next  = START;
          txd_next    = 1'b0;
          baud_next   = '0;
          bit_next    = '0;
        end
      end
      START: begin
        if (baud_done) begin
          state_next = DATA;
          txd_next   = shift_reg[0];
          baud_next  = '0;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            txd_next   = parity_reg;
`else
            state_next = STOP;
            txd_next   = 1'b1;
`endif
          end else begin
            bit_next   = bit_reg + 1'b1;
            shift_next = {1'b0, shift_reg[7:1]};
            txd_next   = shift_reg[1];
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          state_next = STOP;
          txd_next   = 1'b1;
          baud_next  = '0;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
`endif
      STOP: begin
        // Returning to IDLE costs one idle-high clock before the next pop.
        if (baud_done) begin
          state_next = IDLE;
          baud_next  = '0;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_reg     <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      txd_reg    <= txd_next;
      busy_reg   <= (state_next != IDLE) || (count_next != '0);
      count_reg  <= count_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push_req && full && !pop) begin
        overflow_reg <= 1'b1;
      end else if (clr_req) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= WD[7:0];
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio (DIV=10, FIFO_DEPTH=8) with a serial-line monitor.
module tb_uart_tx_mmio;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int          NB = 11;
  localparam logic [31:0] PB = 32'h10;
`else
  localparam int          NB = 10;
  localparam logic [31:0] PB = 32'h0;
`endif
  localparam logic [31:0] TXA = 32'h000000FF;
  localparam logic [31:0] STA = 32'h000000FE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        EN = 1'b0;
  logic [31:0] Address = 32'h0;
  logic [31:0] WD = 32'h0;
  logic [31:0] RD;
  logic        txd;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int p0 = 0;

  logic [7:0] rx_q[$];
  bit         ok_q[$];
  bit         par_q[$];
  int         gap_q[$];
  int         start_q[$];

  uart_tx_mmio #(
    .CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(8),
    .TX_ADDR(32'h000000FF), .STATUS_ADDR(32'h000000FE)
  ) dut (
    .clk(clk), .rst(rst), .Address(Address), .WD(WD), .EN(EN),
    .RD(RD), .txd(txd), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver: samples 2 time units after each rising edge, one sample per clock.
  initial begin
    int         idx;
    int         b;
    int         gap;
    bit         active;
    bit         ok;
    logic [10:0] bits;
    active = 1'b0;
    gap = 0;
    idx = 0;
    ok = 1'b1;
    bits = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        active = 1'b0;
        gap = 0;
      end else if (!active) begin
        if (txd === 1'b0) begin
          active = 1'b1;
          idx = 1;
          bits = '0;
          ok = 1'b1;
          start_q.push_back(cyc);
          gap_q.push_back(gap);
        end else begin
          gap++;
        end
      end else begin
        b = idx / DIV;
        if (idx % DIV == 0) bits[b] = txd;
        else if (txd !== bits[b]) ok = 1'b0;
        idx++;
        if (idx == NB * DIV) begin
          if (bits[NB-1] !== 1'b1) ok = 1'b0;
          rx_q.push_back(bits[8:1]);
          ok_q.push_back(ok);
          par_q.push_back(bits[9]);
          active = 1'b0;
          gap = 0;
        end
      end
    end
  end

  task automatic clear_mon();
    rx_q.delete();
    ok_q.delete();
    par_q.delete();
    gap_q.delete();
    start_q.delete();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int edge_cyc);
    @(negedge clk);
    Address = a;
    WD = d;
    EN = 1'b1;
    @(posedge clk);
    #1;
    edge_cyc = cyc;
    EN = 1'b0;
    Address = 32'h0;
    WD = 32'h0;
  endtask

  task automatic wait_neg(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    Address = STA;
    #1;
    checks++;
    if (RD !== (32'h2 | PB)) begin errors++; $display("FAIL reset_status: got %h expected %h", RD, 32'h2 | PB); end
    Address = 32'h10;
    #1;
    checks++;
    if (RD !== 32'h0) begin errors++; $display("FAIL reset_rd_other: got %h expected 0", RD); end
    Address = 32'h0;
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_single_byte();
    int p, o, fall;
    logic [NB-1:0] fr;
    logic exp;
`ifdef UART_TX_PARITY_EN
    fr = 11'b10010101010;
`else
    fr = 10'b1010101010;
`endif
    clear_mon();
    do_store(TXA, 32'h55, p);
    fall = -1;
    for (int i = 0; i < NB * DIV + 30; i++) begin
      @(negedge clk);
      o = cyc - (p + 1);
      if (o < NB * DIV) begin
        if (o < 0) exp = 1'b1;
        else exp = fr[o / DIV];
        checks++;
        if (txd !== exp) begin
          errors++;
          $display("FAIL single_txd[%0d]: got %b expected %b", o, txd, exp);
        end
      end
      if (fall < 0 && busy === 1'b0) fall = cyc;
    end
    checks++;
    if (fall != p + 1 + NB * DIV) begin
      errors++;
      $display("FAIL single_busy_fall: got cycle %0d expected %0d", fall, p + 1 + NB * DIV);
    end
    checks++;
    if (rx_q.size() != 1) begin
      errors++;
      $display("FAIL single_frames: got %0d expected 1", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 8'h55 || ok_q[0] !== 1'b1) begin
        errors++;
        $display("FAIL single_byte: got %h ok=%b expected 55 ok=1", rx_q[0], ok_q[0]);
      end
      checks++;
      if (start_q[0] != p + 1) begin
        errors++;
        $display("FAIL single_latency: got start %0d expected %0d", start_q[0], p + 1);
      end
    end
    $display("test_single_byte done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_fifo_full();
    int p;
    clear_mon();
    for (int i = 1; i <= 9; i++) begin
      do_store(TXA, i, p);
      if (i == 1) p0 = p;
    end
    @(negedge clk);
    Address = STA;
    #1;
    checks++;
    if (RD !== (32'h5 | PB)) begin errors++; $display("FAIL full_status: got %h expected %h", RD, 32'h5 | PB); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b expected 1", busy); end
    do_store(TXA, 32'h0A, p);
    @(negedge clk);
    Address = STA;
    #1;
    checks++;
    if (RD !== (32'hD | PB)) begin errors++; $display("FAIL overflow_set: got %h expected %h", RD, 32'hD | PB); end
    do_store(STA, 32'hFFFFFFFF, p);
    @(negedge clk);
    Address = STA;
    #1;
    checks++;
    if (RD !== (32'h5 | PB)) begin errors++; $display("FAIL overflow_clr: got %h expected %h", RD, 32'h5 | PB); end
    Address = 32'h0;
    $display("test_fifo_full done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_simul_push_pop();
    int t;
    t = p0 + 2 + NB * DIV;
    wait_neg(t - 1);
    checks++;
    if (cyc != t - 1) begin errors++; $display("FAIL simul_align: got cycle %0d expected %0d", cyc, t - 1); end
    Address = STA;
    #1;
    checks++;
    if (RD !== (32'h1 | PB)) begin errors++; $display("FAIL simul_idle_status: got %h expected %h", RD, 32'h1 | PB); end
    Address = TXA;
    WD = 32'h0B;
    EN = 1'b1;
    @(posedge clk);
    #1;
    EN = 1'b0;
    @(negedge clk);
    Address = STA;
    #1;
    checks++;
    if (RD !== (32'h5 | PB)) begin errors++; $display("FAIL simul_status: got %h expected %h", RD, 32'h5 | PB); end
    Address = 32'h0;
    $display("test_simul_push_pop done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [10];
    for (int i = 0; i < 9; i++) exp_b[i] = 8'(i + 1);
    exp_b[9] = 8'h0B;
    for (int i = 0; i < 1500 && rx_q.size() < 10; i++) @(negedge clk);
    checks++;
    if (rx_q.size() != 10) begin
      errors++;
      $display("FAIL b2b_frames: got %0d expected 10", rx_q.size());
    end else begin
      checks++;
      if (start_q[0] != p0 + 1) begin
        errors++;
        $display("FAIL b2b_first_start: got %0d expected %0d", start_q[0], p0 + 1);
      end
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (rx_q[i] !== exp_b[i] || ok_q[i] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_byte[%0d]: got %h ok=%b expected %h ok=1", i, rx_q[i], ok_q[i], exp_b[i]);
        end
        if (i > 0) begin
          checks++;
          if (gap_q[i] != 1) begin
            errors++;
            $display("FAIL b2b_gap[%0d]: got %0d expected 1", i, gap_q[i]);
          end
        end
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
    Address = STA;
    #1;
    checks++;
    if (RD !== (32'h2 | PB)) begin errors++; $display("FAIL b2b_status_end: got %h expected %h", RD, 32'h2 | PB); end
    Address = 32'h0;
    $display("test_back_to_back done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_status_read();
    int p;
    clear_mon();
    do_store(TXA, 32'h31, p);
    do_store(TXA, 32'h32, p);
    do_store(TXA, 32'h33, p);
    @(negedge clk);
    Address = STA;
    #1;
    checks++;
    if (RD !== (32'h4 | PB)) begin errors++; $display("FAIL status_two_queued: got %h expected %h", RD, 32'h4 | PB); end
    Address = 32'h10;
    #1;
    checks++;
    if (RD !== 32'h0) begin errors++; $display("FAIL status_other_addr: got %h expected 0", RD); end
    Address = TXA;
    #1;
    checks++;
    if (RD !== 32'h0) begin errors++; $display("FAIL status_tx_addr: got %h expected 0", RD); end
    Address = 32'h0;
    for (int i = 0; i < 400 && rx_q.size() < 3; i++) @(negedge clk);
    checks++;
    if (rx_q.size() != 3) begin
      errors++;
      $display("FAIL status_frames: got %0d expected 3", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 8'h31 || rx_q[1] !== 8'h32 || rx_q[2] !== 8'h33) begin
        errors++;
        $display("FAIL status_bytes: got %h %h %h expected 31 32 33", rx_q[0], rx_q[1], rx_q[2]);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL status_busy_end: got %b expected 0", busy); end
    $display("test_status_read done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid_frame();
    int p, s;
    bit saw_low;
    clear_mon();
    do_store(TXA, 32'hA5, p);
    s = p + 1;
    do_store(TXA, 32'h11, p);
    do_store(TXA, 32'h22, p);
    do_store(TXA, 32'h33, p);
    wait_neg(s + 43);
    checks++;
    if (txd !== 1'b0) begin errors++; $display("FAIL midframe_bit3: got %b expected 0", txd); end
    Address = STA;
    #1;
    checks++;
    if (RD !== (32'h4 | PB)) begin errors++; $display("FAIL midframe_status: got %h expected %h", RD, 32'h4 | PB); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL rstmid_txd: got %b expected 1", txd); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++;
    if (RD !== (32'h2 | PB)) begin errors++; $display("FAIL rstmid_status: got %h expected %h", RD, 32'h2 | PB); end
    Address = 32'h0;
    saw_low = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) saw_low = 1'b1;
    end
    checks++;
    if (saw_low || rx_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_no_frames: got low=%b frames=%0d expected low=0 frames=0", saw_low, rx_q.size());
    end
    $display("test_reset_mid_frame done: checks=%0d errors=%0d", checks, errors);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] data [2];
    bit         par [2];
    int p, fall;
    data[0] = 8'h07; par[0] = 1'b1;
    data[1] = 8'h03; par[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      do_store(TXA, 32'(data[k]), p);
      fall = -1;
      for (int i = 0; i < NB * DIV + 30; i++) begin
        @(negedge clk);
        if (fall < 0 && busy === 1'b0) fall = cyc;
      end
      checks++;
      if (fall != p + 111) begin
        errors++;
        $display("FAIL parity_len[%0d]: got fall %0d expected %0d", k, fall, p + 111);
      end
      checks++;
      if (rx_q.size() != 1) begin
        errors++;
        $display("FAIL parity_frames[%0d]: got %0d expected 1", k, rx_q.size());
      end else begin
        checks++;
        if (rx_q[0] !== data[k] || par_q[0] !== par[k] || ok_q[0] !== 1'b1) begin
          errors++;
          $display("FAIL parity_bit[%0d]: got %h par=%b ok=%b expected %h par=%b ok=1",
                   k, rx_q[0], par_q[0], ok_q[0], data[k], par[k]);
        end
      end
    end
    $display("test_parity done: checks=%0d errors=%0d", checks, errors);
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_fifo_full();
    test_simul_push_pop();
    test_back_to_back();
    test_status_read();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
